dm_port_arbiter: RTL and testbench

Sequencer and two-way arbiter in front of the byte-wide data memory array. It serves MIPS load/store requests from the CPU pipeline and a secondary master (DMA/debug loader) over a single 8-bit memory port. It splits each word/halfword/byte access into byte cycles and applies lh/lb sign or zero extension. It returns the assembled result with a one-cycle acknowledge.

---
 rtl/dm_port_arbiter_if.sv | 43 ++++
 rtl/dm_port_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_port_arbiter_if.sv
// Bundle of the two master request/ack channels and the byte-wide memory port
// that dm_port_arbiter sits between.
interface dm_port_arbiter_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              cpu_req;
  logic [5:0]        cpu_op;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_ack;
  logic [31:0]       cpu_rdata;

  logic              dma_req;
  logic [5:0]        dma_op;
  logic [ADDR_W-1:0] dma_addr;
  logic [31:0]       dma_wdata;
  logic              dma_ack;
  logic [31:0]       dma_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;

  logic              busy;
  logic              err;

  modport master (
    output cpu_req, cpu_op, cpu_addr, cpu_wdata,
    output dma_req, dma_op, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    input  mem_addr, mem_wdata, mem_we, busy, err
  );

  modport slave (
    input  cpu_req, cpu_op, cpu_addr, cpu_wdata,
    input  dma_req, dma_op, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    output mem_addr, mem_wdata, mem_we, busy, err
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-master arbiter and byte sequencer for the 8-bit data memory port:
// splits MIPS loads/stores into byte cycles and extends load results.
module dm_port_arbiter #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  dm_port_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] OP_LB  = 6'd32;
  localparam logic [5:0] OP_LH  = 6'd33;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_LBU = 6'd36;
  localparam logic [5:0] OP_LHU = 6'd37;
  localparam logic [5:0] OP_SB  = 6'd40;
  localparam logic [5:0] OP_SH  = 6'd41;
  localparam logic [5:0] OP_SW  = 6'd43;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: is_legal = 1'b1;
      default:                                                  is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] last_idx(input logic [5:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: last_idx = 2'd1;
      OP_LW, OP_SW:         last_idx = 2'd3;
      default:              last_idx = 2'd0;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] base_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [5:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: base_addr = {a[ADDR_W-1:1], 1'b0};
      OP_LW, OP_SW:         base_addr = {a[ADDR_W-1:2], 2'b00};
      default:              base_addr = a;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] v);
    case (op)
      OP_LH:   extend = {{16{v[15]}}, v[15:0]};
      OP_LHU:  extend = {16'h0000, v[15:0]};
      OP_LB:   extend = {{24{v[7]}}, v[7:0]};
      OP_LBU:  extend = {24'h000000, v[7:0]};
      default: extend = v;
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic              sel_dma_q, sel_dma_d;
  logic              prio_dma_q, prio_dma_d;
  logic [5:0]        op_q, op_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       dma_rdata_q, dma_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dma_ack_q, dma_ack_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;

  logic              grant_dma;
  logic [5:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [31:0]       asm_byte;

  // DMA wins only when it is alone or it is its turn on a tie.
  assign grant_dma = bus.dma_req & (~bus.cpu_req | prio_dma_q);
  assign req_op    = grant_dma ? bus.dma_op    : bus.cpu_op;
  assign req_addr  = grant_dma ? bus.dma_addr  : bus.cpu_addr;
  assign req_wdata = grant_dma ? bus.dma_wdata : bus.cpu_wdata;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    sel_dma_d   = sel_dma_q;
    prio_dma_d  = prio_dma_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    err_d       = 1'b0;
    asm_byte    = asm_q;
    asm_byte[{k_q, 3'b000} +: 8] = bus.mem_rdata;

    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          sel_dma_d  = grant_dma;
          prio_dma_d = ~grant_dma;
          op_d       = req_op;
          wdata_d    = req_wdata;
          k_d        = 2'd0;
          asm_d      = '0;
          if (is_legal(req_op)) begin
            state_d    = S_XFER;
            mem_addr_d = base_addr(req_addr, req_op);
            mem_we_d   = is_store(req_op);
            if (is_store(req_op)) mem_wdata_d = req_wdata[7:0];
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
            if (grant_dma) begin
              dma_ack_d   = 1'b1;
              dma_rdata_d = '0;
            end else begin
              cpu_ack_d   = 1'b1;
              cpu_rdata_d = '0;
            end
          end
        end
      end
      S_XFER: begin
        if (!is_store(op_q)) asm_d = asm_byte;
        if (k_q == last_idx(op_q)) begin
          state_d  = S_DONE;
          mem_we_d = 1'b0;
          if (sel_dma_q) dma_ack_d = 1'b1;
          else           cpu_ack_d = 1'b1;
          // Result is built from asm_byte so the final byte lands in the same edge.
          if (!is_store(op_q)) begin
            if (sel_dma_q) dma_rdata_d = extend(op_q, asm_byte);
            else           cpu_rdata_d = extend(op_q, asm_byte);
          end
        end else begin
          k_d        = k_q + 2'd1;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          if (is_store(op_q)) begin
            wdata_d     = {8'h00, wdata_q[31:8]};
            mem_wdata_d = wdata_q[15:8];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      sel_dma_q   <= 1'b0;
      prio_dma_q  <= 1'b0;
      op_q        <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      sel_dma_q   <= sel_dma_d;
      prio_dma_q  <= prio_dma_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: directed transactions push expected
// acks and byte writes; a negedge monitor pops and compares them.
module tb_dm_port_arbiter;
  localparam int unsigned AW = 14;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_port_arbiter_if #(.ADDR_W(AW)) bus ();
  dm_port_arbiter #(.ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] mem [0:(1<<AW)-1];
  logic       mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'h00;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  typedef struct { bit dma; logic [31:0] rdata; bit err; } ack_t;
  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  ack_t ackq[$];
  wr_t  wrq[$];

  int nvec = 0;
  int nfail = 0;
  bit mon_en = 1'b0;
  logic [31:0] cpu_rd_exp, dma_rd_exp;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.cpu_ack && bus.dma_ack) begin
        nvec++; nfail++;
        $display("FAIL both_ack: cpu_ack=1 dma_ack=1, required at most one");
      end
      if (bus.cpu_ack || bus.dma_ack) begin
        nvec++;
        if (ackq.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_ack: cpu_ack=%0b dma_ack=%0b with nothing pending", bus.cpu_ack, bus.dma_ack);
        end else begin
          ack_t e;
          logic [31:0] r;
          e = ackq.pop_front();
          r = bus.dma_ack ? bus.dma_rdata : bus.cpu_rdata;
          if (bus.dma_ack != e.dma || r !== e.rdata || bus.err != e.err) begin
            nfail++;
            $display("FAIL ack_check: got dma=%0b rdata=%h err=%0b, required dma=%0b rdata=%h err=%0b",
                     bus.dma_ack, r, bus.err, e.dma, e.rdata, e.err);
          end
        end
      end else if (bus.err) begin
        nvec++; nfail++;
        $display("FAIL err_no_ack: err=1 without ack, required 0");
      end
      if (bus.mem_we) begin
        nvec++;
        if (wrq.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_write: addr=%h data=%h with nothing pending", bus.mem_addr, bus.mem_wdata);
        end else begin
          wr_t w;
          w = wrq.pop_front();
          if (bus.mem_addr !== w.a || bus.mem_wdata !== w.d) begin
            nfail++;
            $display("FAIL write_check: got addr=%h data=%h, required addr=%h data=%h",
                     bus.mem_addr, bus.mem_wdata, w.a, w.d);
          end
        end
      end
    end
  end

  task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a; w.d = d;
    wrq.push_back(w);
  endtask

  task automatic push_ack(input bit dma, input logic [31:0] r, input bit er);
    ack_t e;
    e.dma = dma; e.rdata = r; e.err = er;
    ackq.push_back(e);
  endtask

  task automatic check_zero(input string name);
    logic [90:0] v;
    v = {bus.cpu_ack, bus.dma_ack, bus.err, bus.busy, bus.mem_we,
         bus.cpu_rdata, bus.dma_rdata, bus.mem_addr, bus.mem_wdata};
    nvec++;
    if (v !== '0) begin
      nfail++;
      $display("FAIL %s: outputs=%h, required all 0", name, v);
    end
  endtask

  task automatic check_mem(input string name, input logic [AW-1:0] a, input logic [7:0] d);
    nvec++;
    if (mem[a] !== d) begin
      nfail++;
      $display("FAIL %s: mem[%h]=%h, required %h", name, a, mem[a], d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cpu_rd_exp = '0;
    dma_rd_exp = '0;
  endtask

  task automatic wait_ack(input bit dma, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = dma ? bus.dma_ack : bus.cpu_ack;
    end
    nvec++;
    if (!got) begin
      nfail++;
      $display("FAIL %s: no ack within 60 cycles, required an ack", name);
    end
  endtask

  task automatic run(input bit dma, input logic [5:0] op, input logic [AW-1:0] addr,
                     input logic [31:0] wd, input bit ld, input logic [31:0] rd,
                     input bit er, input int lat, input string name);
    logic [31:0] r;
    bit got;
    int cnt;
    r = ld ? rd : (dma ? dma_rd_exp : cpu_rd_exp);
    if (dma) dma_rd_exp = r;
    else     cpu_rd_exp = r;
    push_ack(dma, r, er);
    @(negedge clk);
    if (dma) begin
      bus.dma_req = 1'b1; bus.dma_op = op; bus.dma_addr = addr; bus.dma_wdata = wd;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_op = op; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    end
    got = 1'b0;
    cnt = 0;
    while (!got && cnt < 40) begin
      @(negedge clk);
      cnt++;
      got = dma ? bus.dma_ack : bus.cpu_ack;
    end
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    nvec++;
    if (!got || cnt != lat) begin
      nfail++;
      $display("FAIL %s_latency: ack after %0d cycles (seen=%0b), required %0d", name, cnt, got, lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    rst_n = 1'b0;
    mem_clr = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_op = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_op = '0; bus.dma_addr = '0; bus.dma_wdata = '0;
    cpu_rd_exp = '0;
    dma_rd_exp = '0;
    @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    do_reset();
    check_zero("reset_state");
    mon_en = 1'b1;

    // word store then unaligned word load
    push_wr(14'h10, 8'hEF); push_wr(14'h11, 8'hBE);
    push_wr(14'h12, 8'hAD); push_wr(14'h13, 8'hDE);
    run(0, 6'd43, 14'h10, 32'hDEADBEEF, 0, '0, 0, 5, "sw");
    run(0, 6'd35, 14'h13, '0, 1, 32'hDEADBEEF, 0, 5, "lw");

    // halfword store and the four extending loads
    push_wr(14'h20, 8'h81); push_wr(14'h21, 8'h80);
    run(0, 6'd41, 14'h21, 32'h00008081, 0, '0, 0, 3, "sh");
    run(0, 6'd33, 14'h20, '0, 1, 32'hFFFF8081, 0, 3, "lh");
    run(0, 6'd37, 14'h20, '0, 1, 32'h00008081, 0, 3, "lhu");
    run(0, 6'd32, 14'h21, '0, 1, 32'hFFFFFF80, 0, 2, "lb");
    run(0, 6'd36, 14'h21, '0, 1, 32'h00000080, 0, 2, "lbu");

    // illegal opcode: immediate DONE, rdata forced to 0, no memory cycle
    run(0, 6'd50, 14'h30, 32'h12345678, 1, 32'h0, 1, 1, "illegal");

    // DMA sb with req dropped after one cycle
    push_wr(14'h05, 8'h5A);
    push_ack(1, dma_rd_exp, 0);
    @(negedge clk);
    bus.dma_req = 1'b1; bus.dma_op = 6'd40; bus.dma_addr = 14'h05; bus.dma_wdata = 32'h0000005A;
    @(negedge clk);
    bus.dma_req = 1'b0;
    acks = int'(bus.dma_ack);
    repeat (12) begin
      @(negedge clk);
      acks += int'(bus.dma_ack);
    end
    nvec++;
    if (acks != 1) begin
      nfail++;
      $display("FAIL req_drop_acks: dma_ack pulses=%0d, required 1", acks);
    end
    check_mem("req_drop_mem", 14'h05, 8'h5A);

    // simultaneous requests held for four transactions
    do_reset();
    push_ack(0, 32'h000000EF, 0);
    push_ack(1, 32'h000000BE, 0);
    push_ack(0, 32'h0000DEAD, 0);
    push_ack(1, 32'hDEADBEEF, 0);
    cpu_rd_exp = 32'h0000DEAD;
    dma_rd_exp = 32'hDEADBEEF;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_op = 6'd36; bus.cpu_addr = 14'h10;
    bus.dma_req = 1'b1; bus.dma_op = 6'd36; bus.dma_addr = 14'h11;
    fork
      begin
        wait_ack(0, "arb_cpu1");
        bus.cpu_op = 6'd37; bus.cpu_addr = 14'h12;
        wait_ack(0, "arb_cpu2");
        bus.cpu_req = 1'b0;
      end
      begin
        wait_ack(1, "arb_dma1");
        bus.dma_op = 6'd35; bus.dma_addr = 14'h10;
        wait_ack(1, "arb_dma2");
        bus.dma_req = 1'b0;
      end
    join

    // reset asserted so that it is sampled at the start of the third sw byte
    push_wr(14'h40, 8'h44); push_wr(14'h41, 8'h33);
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_op = 6'd43; bus.cpu_addr = 14'h40; bus.cpu_wdata = 32'h11223344;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check_zero("reset_mid_sw");
    rst_n = 1'b1;
    cpu_rd_exp = '0;
    dma_rd_exp = '0;
    check_mem("reset_mid_b0", 14'h40, 8'h44);
    check_mem("reset_mid_b1", 14'h41, 8'h33);
    check_mem("reset_mid_b2", 14'h42, 8'h00);
    run(0, 6'd35, 14'h40, '0, 1, 32'h00003344, 0, 5, "lw_after_reset");
    run(1, 6'd32, 14'h20, '0, 1, 32'hFFFFFF81, 0, 2, "dma_lb");

    repeat (5) @(negedge clk);
    nvec++;
    if (ackq.size() != 0 || wrq.size() != 0) begin
      nfail++;
      $display("FAIL drain: pending acks=%0d writes=%0d, required 0 and 0", ackq.size(), wrq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
